// File: rtl/bus_pkg.sv
// Shared system-bus definitions: word geometry, access encodings, active-low
// control levels and the responder state enumeration.
package bus_pkg;

  localparam int WORD_W      = 32;
  localparam int WORD_ADDR_W = 30;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // state | meaning
  // IDLE  | waiting for a selected address strobe
  // WAIT  | inserting wait states, counter running down
  // READY | memory access done; ready pulse is issued on the next edge
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } bus_state_e;

endpackage

// File: rtl/spram_word.sv
// Single-port word RAM, synchronous write and synchronous read.
// Contents are deliberately not reset.
module spram_word
  import bus_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_slave_ram.sv
// Word-addressed RAM target on the shared bus: one access per strobe, a fixed
// number of wait states, a one-cycle active-low ready and OR-mergeable read data.
module bus_slave_ram
  import bus_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_cs_,
  input  logic                   s_as_,
  input  logic                   s_rw,
  input  logic [WORD_ADDR_W-1:0] s_addr,
  input  logic [WORD_W-1:0]      s_wr_data,
  output logic [WORD_W-1:0]      s_rd_data,
  output logic                   s_rdy_,
  output logic                   busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  bus_state_e        state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_rw;
  logic [WORD_W-1:0] cap_wdata;

  logic              accept;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  logic              rdy_q;
  logic              busy_q;
  logic [WORD_W-1:0] rd_data_q;

  logic              unused_addr_hi;
  assign unused_addr_hi = ^s_addr[WORD_ADDR_W-1:ADDR_W];

  // The ready cycle itself is spent in IDLE, so the registered ready blocks
  // a strobe that lands on it.
  assign accept = (state == IDLE) && (rdy_q == DISABLE_) &&
                  (s_cs_ == ENABLE_) && (s_as_ == ENABLE_);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cap_addr;
    mem_wdata = cap_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            // Zero wait states: access the array straight from the bus.
            state_nx  = READY;
            mem_en    = 1'b1;
            mem_we    = (s_rw == WRITE);
            mem_addr  = s_addr[ADDR_W-1:0];
            mem_wdata = s_wr_data;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nx = READY;
          mem_en   = 1'b1;
          mem_we   = (cap_rw == WRITE);
        end
      end
      READY: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_addr  <= '0;
      cap_rw    <= READ;
      cap_wdata <= '0;
      rdy_q     <= DISABLE_;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        cap_addr  <= s_addr[ADDR_W-1:0];
        cap_rw    <= s_rw;
        cap_wdata <= s_wr_data;
      end
      rdy_q     <= (state == READY) ? ENABLE_ : DISABLE_;
      busy_q    <= accept || (state != IDLE);
      rd_data_q <= ((state == READY) && (cap_rw == READ)) ? mem_rdata : '0;
    end
  end

  spram_word #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  assign s_rdy_    = rdy_q;
  assign busy      = busy_q;
  assign s_rd_data = rd_data_q;

endmodule

// File: tb/tb_bus_slave_ram.sv
// Bench for bus_slave_ram: three builds (0, 1 and 3 wait states) driven by
// directed and random strobes, checked by a queue-based scoreboard.
module tb_bus_slave_ram;
  import bus_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n  [3];
  logic        as_n  [3];
  logic        rw    [3];
  logic [29:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        rdy_n [3];
  logic        busy  [3];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          last_t [3] = '{-100, -100, -100};
  logic [31:0] mem_m [3][1024];
  exp_t        exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_slave_ram #(
      .ADDR_W     (10),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .s_cs_    (cs_n[g]),
      .s_as_    (as_n[g]),
      .s_rw     (rw[g]),
      .s_addr   (addr[g]),
      .s_wr_data(wdata[g]),
      .s_rd_data(rdata[g]),
      .s_rdy_   (rdy_n[g]),
      .busy     (busy[g])
    );
  end

  function automatic int wc(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the strobe is sampled at the next rising edge.
  task automatic strobe(input int i, input logic r, input logic [29:0] a,
                        input logic [31:0] d, input logic c, input bit abort);
    int   t;
    exp_t e;
    cs_n[i]  = c;
    as_n[i]  = 1'b0;
    rw[i]    = r;
    addr[i]  = a;
    wdata[i] = d;
    t = cyc + 1;
    if (c == 1'b0 && t >= last_t[i] + wc(i) + 3) begin
      last_t[i] = t;
      if (!abort) begin
        e.cyc = t + 1 + wc(i);
        if (r == WRITE) begin
          mem_m[i][a[9:0]] = d;
          e.data = 32'h0;
        end else begin
          e.data = mem_m[i][a[9:0]];
        end
        exp_q[i].push_back(e);
      end
    end
    @(negedge clk);
    cs_n[i] = 1'b1;
    as_n[i] = 1'b1;
  endtask

  task automatic op(input int i, input logic r, input logic [29:0] a, input logic [31:0] d);
    strobe(i, r, a, d, 1'b0, 1'b0);
    idle(6);
  endtask

  // Monitor: pops the scoreboard on every ready pulse, checks idle outputs otherwise.
  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rdy_n[i] === 1'b0) begin
        if (exp_q[i].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ready: dut %0d got ready at cycle %0d, required none", i, cyc);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("ready_cycle_dut%0d", i), 32'(cyc), 32'(e.cyc));
          chk($sformatf("rd_data_dut%0d", i), rdata[i], e.data);
        end
      end else begin
        chk($sformatf("rdy_idle_dut%0d", i), 32'(rdy_n[i]), 32'd1);
        chk($sformatf("rd_data_zero_dut%0d", i), rdata[i], 32'h0);
        if (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
          e = exp_q[i].pop_front();
          chk($sformatf("missing_ready_dut%0d", i), 32'(cyc), 32'(e.cyc));
        end
      end
      chk($sformatf("busy_dut%0d", i), 32'(busy[i]),
          32'((cyc >= last_t[i]) && (cyc <= last_t[i] + wc(i) + 1)));
    end
  end

  initial begin
    logic [29:0] a;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cs_n[i] = 1'b1; as_n[i] = 1'b1; rw[i] = READ; addr[i] = '0; wdata[i] = '0;
    end
    idle(3);
    for (int i = 0; i < 3; i++) begin
      chk("reset_rdy", 32'(rdy_n[i]), 32'd1);
      chk("reset_rd_data", rdata[i], 32'h0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
    end
    reset = 1'b0;
    idle(2);

    // Write then read back, one wait state.
    op(1, WRITE, 30'h005, 32'hDEADBEEF);
    op(1, READ,  30'h005, 32'h0);

    // Preload a working region in every build, then read back in 0 and 3 wait-state builds.
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 8; k++)
        op(i, WRITE, 30'h020 + 30'(k), $urandom);
    op(0, READ, 30'h023, 32'h0);
    op(2, READ, 30'h026, 32'h0);

    // Deselected strobe must neither respond nor write.
    strobe(1, WRITE, 30'h020, 32'h0BAD0BAD, 1'b1, 1'b0);
    idle(6);
    op(1, READ, 30'h020, 32'h0);

    // Strobe while busy and strobe on the ready cycle are both ignored.
    strobe(1, WRITE, 30'h030, 32'hAAAA5555, 1'b0, 1'b0);
    strobe(1, WRITE, 30'h030, 32'h12345678, 1'b0, 1'b0);
    idle(1);
    strobe(1, WRITE, 30'h030, 32'h87654321, 1'b0, 1'b0);
    idle(6);
    op(1, READ, 30'h030, 32'h0);

    // Aliasing above the decoded address bits.
    op(1, WRITE, 30'h3FF, 32'h11111111);
    op(1, WRITE, 30'h7FF, 32'h22222222);
    op(1, READ,  30'h3FF, 32'h0);

    // Reset during the wait state of a write aborts it.
    op(1, WRITE, 30'h010, 32'h0);
    strobe(1, WRITE, 30'h010, 32'hCAFEF00D, 1'b0, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) last_t[i] = -100;
    #1;
    chk("abort_rdy", 32'(rdy_n[1]), 32'd1);
    chk("abort_busy", 32'(busy[1]), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(2);
    op(1, READ, 30'h010, 32'h0);

    // Back-to-back reads, re-strobe on the cycle after ready.
    op(1, WRITE, 30'h001, 32'h0000AAA1);
    op(1, WRITE, 30'h002, 32'h0000BBB2);
    strobe(1, READ, 30'h001, 32'h0, 1'b0, 1'b0);
    idle(wc(1) + 2);
    strobe(1, READ, 30'h002, 32'h0, 1'b0, 1'b0);
    idle(6);

    // Random traffic across all builds, including overlapping and deselected strobes.
    for (int n = 0; n < 300; n++) begin
      int i;
      i = $urandom_range(0, 2);
      idle($urandom_range(0, 4));
      a = 30'($urandom);
      a[9:0] = 10'h020 + 10'($urandom_range(0, 7));
      strobe(i, logic'($urandom_range(0, 1)), a, $urandom,
             logic'($urandom_range(0, 7) == 0), 1'b0);
    end
    idle(10);
    for (int i = 0; i < 3; i++)
      chk($sformatf("queue_empty_dut%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
